// File: rtl/motor_relu_stream_if.sv
// motor_relu_stream_if: valid/ready input and output streams of the activation stage
interface motor_relu_stream_if #(
  parameter int W = 18,
  parameter int CH = 2
);
  logic [CH*W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [CH*W-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
endinterface

// File: rtl/motor_relu_stream.sv
// motor_relu_stream: two-stage valid/ready ReLU / clipped / leaky / pass-through stage with saturating clip counter
module motor_relu_stream #(
  parameter int W = 18,
  parameter int I = 7,
  parameter int CH = 2,
  parameter int LEAK_SHIFT = 3,
  parameter int CLIP = 12288
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [1:0]          cfg_mode,
  motor_relu_stream_if.slave  s,
  output logic [15:0]         clip_count
);
  if (I < 1 || I > W || LEAK_SHIFT < 1 || LEAK_SHIFT >= W) $error("motor_relu_stream: bad parameters");
  localparam logic signed [W-1:0] CLIP_V = W'(CLIP);
  logic            s1_valid_q;
  logic [CH*W-1:0] s1_data_q;
  logic [1:0]      s1_mode_q;
  logic [CH-1:0]   s1_neg_q, s1_clip_q, neg_d, clip_d, hit;
  logic            out_valid_q;
  logic [CH*W-1:0] out_data_q, res_d;
  logic [15:0]     clip_count_q, clip_count_d;
  logic [16:0]     sum;
  logic            s2_load, s1_adv, accept;
  assign s2_load    = !out_valid_q || s.out_ready;
  assign s1_adv     = s1_valid_q && s2_load;
  assign s.in_ready = !ap_rst && (!s1_valid_q || s2_load);
  assign accept     = s.in_valid && s.in_ready;
  assign s.out_data  = out_data_q;
  assign s.out_valid = out_valid_q;
  assign clip_count  = clip_count_q;
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic signed [W-1:0] x, sh;
    assign neg_d[k]  = s.in_data[k*W+W-1];
    assign clip_d[k] = $signed(s.in_data[k*W +: W]) > CLIP_V;
    assign x         = s1_data_q[k*W +: W];
    assign sh        = x >>> LEAK_SHIFT;
    assign hit[k]    = s1_clip_q[k] && s1_mode_q == 2'd1;
    always_comb
      res_d[k*W +: W] = s1_mode_q == 2'd3 ? x :
                        s1_neg_q[k] ? (s1_mode_q == 2'd2 ? sh : '0) :
                        hit[k] ? CLIP_V : x;
  end
  // Wide sum so a multi-channel increment saturates instead of wrapping
  always_comb begin
    sum = {1'b0, clip_count_q};
    for (int i = 0; i < CH; i++) sum = sum + 17'(hit[i]);
    clip_count_d = sum[16] ? 16'hFFFF : sum[15:0];
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      clip_count_q <= '0;
    end else begin
      if (s.in_ready) s1_valid_q <= s.in_valid;
      if (s2_load) out_valid_q <= s1_valid_q;
      if (s1_adv) begin
        out_data_q   <= res_d;
        clip_count_q <= clip_count_d;
      end
    end
  end
  always_ff @(posedge ap_clk) begin
    if (accept) begin
      s1_data_q <= s.in_data;
      s1_mode_q <= cfg_mode;
      s1_neg_q  <= neg_d;
      s1_clip_q <= clip_d;
    end
  end
endmodule
